piso_tx_ctrl: RTL and testbench

Transmit sequencer for the 8-bit parallel-in/serial-out shift register. It accepts one data word per valid/ready handshake and drives the register's load/shift select. It counts bits and bit-period clocks, and frames the serial stream with an active strobe and an end-of-word pulse. It sits between a byte producer and the serial line, and owns one PISO instance.

---
 rtl/piso_tx_ctrl_pkg.sv | 20 ++
 rtl/piso_shift_reg.sv | 36 +++
 rtl/piso_tx_ctrl.sv | 112 +++++++++++
 tb/tb_piso_tx_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_ctrl_pkg.sv
// Shared definitions for the PISO transmit sequencer.
//   state_e    : controller FSM states (Idle, Shift, Done)
//   SelLoad/SelShift : PISO select encoding (0 = parallel load, 1 = shift)
//   cnt_width  : counter width helper, never narrower than 1 bit
package piso_tx_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   localparam logic SelLoad  = 1'b0;
   localparam logic SelShift = 1'b1;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register, MSB first.
//   clk, rst_n   : clock, asynchronous active-low reset (contents cleared)
//   sel_p_s      : 0 = parallel load, 1 = shift toward the MSB
//   shift_en     : enables the selected operation; register holds otherwise
//   parallel_in  : word to load
//   serial_out   : current MSB
module piso_shift_reg
   import piso_tx_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sel_p_s,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] parallel_in,
   output logic              serial_out
);

   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else if (shift_en) begin
         if (sel_p_s == SelShift) begin
            r_data <= {r_data[DATA_W-2:0], 1'b0};
         end else begin
            r_data <= parallel_in;
         end
      end
   end

   assign serial_out = r_data[DATA_W-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Transmit sequencer: accepts one word per valid/ready handshake, loads the
// PISO and shifts it out MSB first, holding each bit for BIT_DIV clocks.
//   clk, rst_n          : clock, asynchronous active-low reset
//   tx_data, tx_valid   : producer word and its valid
//   tx_ready            : registered; high in Idle/Done (low during reset)
//   ser_out, ser_active : serial bit (gated to 0 when inactive) and its strobe
//   busy                : high while a word is being shifted
//   done                : one-cycle pulse after the last bit period
module piso_tx_ctrl
   import piso_tx_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned BIT_DIV = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              ser_out,
   output logic              ser_active,
   output logic              busy,
   output logic              done
);

   localparam int unsigned   BitW    = cnt_width(DATA_W);
   localparam int unsigned   DivW    = cnt_width(BIT_DIV);
   localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);
   localparam logic [DivW-1:0] DivLast = DivW'(BIT_DIV - 1);

   state_e          r_state, w_state_next;
   logic [BitW-1:0] r_bit_cnt, w_bit_cnt_next;
   logic [DivW-1:0] r_div_cnt, w_div_cnt_next;
   logic            r_tx_ready;
   logic            w_accept;
   logic            w_sel;
   logic            w_shift_en;
   logic            w_msb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_bit_cnt  <= '0;
         r_div_cnt  <= '0;
         r_tx_ready <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_bit_cnt  <= w_bit_cnt_next;
         r_div_cnt  <= w_div_cnt_next;
         // Ready is registered so it stays low for the first cycle out of reset.
         r_tx_ready <= (w_state_next != StShift);
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_bit_cnt_next = r_bit_cnt;
      w_div_cnt_next = r_div_cnt;
      w_sel          = SelLoad;
      w_shift_en     = 1'b0;
      w_accept       = tx_valid && r_tx_ready;

      unique case (r_state)
         StIdle, StDone: begin
            if (w_accept) begin
               w_state_next   = StShift;
               w_bit_cnt_next = '0;
               w_div_cnt_next = '0;
               w_shift_en     = 1'b1;
            end else begin
               w_state_next = StIdle;
            end
         end
         StShift: begin
            if (r_div_cnt == DivLast) begin
               w_div_cnt_next = '0;
               if (r_bit_cnt == BitLast) begin
                  // Last bit period ends; the register is left unshifted.
                  w_state_next = StDone;
               end else begin
                  w_bit_cnt_next = r_bit_cnt + 1'b1;
                  w_sel          = SelShift;
                  w_shift_en     = 1'b1;
               end
            end else begin
               w_div_cnt_next = r_div_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   piso_shift_reg #(
      .DATA_W (DATA_W)
   ) u_piso (
      .clk         (clk),
      .rst_n       (rst_n),
      .sel_p_s     (w_sel),
      .shift_en    (w_shift_en),
      .parallel_in (tx_data),
      .serial_out  (w_msb)
   );

   assign tx_ready   = r_tx_ready;
   assign ser_active = (r_state == StShift);
   assign busy       = (r_state == StShift);
   assign done       = (r_state == StDone);
   assign ser_out    = w_msb && ser_active;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Scoreboard bench for piso_tx_ctrl: one instance with BIT_DIV=1, one with
// BIT_DIV=3. Stimulus pushes the expected per-cycle output of each accepted
// word; a negedge monitor pops and compares whenever a DUT is active or done.
module tb_piso_tx_ctrl;

   typedef struct {
      int         cyc;
      logic [4:0] v;   // {ser_out, ser_active, busy, done, tx_ready}
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data1, tx_data3;
   logic       tx_valid1, tx_valid3;
   logic       tx_ready1, ser_out1, ser_active1, busy1, done1;
   logic       tx_ready3, ser_out3, ser_active3, busy3, done3;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q1[$];
   exp_t q3[$];
   exp_t e1, e3;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   piso_tx_ctrl #(.DATA_W(8), .BIT_DIV(1)) u_dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_data    (tx_data1),
      .tx_valid   (tx_valid1),
      .tx_ready   (tx_ready1),
      .ser_out    (ser_out1),
      .ser_active (ser_active1),
      .busy       (busy1),
      .done       (done1)
   );

   piso_tx_ctrl #(.DATA_W(8), .BIT_DIV(3)) u_dut3 (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_data    (tx_data3),
      .tx_valid   (tx_valid3),
      .tx_ready   (tx_ready3),
      .ser_out    (ser_out3),
      .ser_active (ser_active3),
      .busy       (busy3),
      .done       (done3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected trace of one word accepted at the edge following cycle 'acc'.
   task automatic push_frame(input int which, input logic [7:0] d, input int div,
                             input int acc);
      exp_t e;
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < div; j++) begin
            e.cyc = acc + 1 + k * div + j;
            e.v   = {d[7-k], 1'b1, 1'b1, 1'b0, 1'b0};
            if (which == 1) q1.push_back(e); else q3.push_back(e);
         end
      end
      e.cyc = acc + 8 * div + 1;
      e.v   = 5'b00011;
      if (which == 1) q1.push_back(e); else q3.push_back(e);
   endtask

   // Called at a negedge; leaves tx_valid high and returns at the negedge after acceptance.
   task automatic send(input int which, input logic [7:0] d, output int acc);
      logic rdy;
      acc = -1;
      if (which == 1) begin tx_data1 = d; tx_valid1 = 1'b1; end
      else            begin tx_data3 = d; tx_valid3 = 1'b1; end
      for (int i = 0; i < 100; i++) begin
         rdy = (which == 1) ? tx_ready1 : tx_ready3;
         if (rdy) begin
            acc = cyc;
            break;
         end
         @(negedge clk);
      end
      check("send_accepted", 32'(acc >= 0), 32'd1);
      if (acc >= 0) push_frame(which, d, (which == 1) ? 1 : 3, acc);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input int which);
      int sz;
      for (int i = 0; i < 400; i++) begin
         sz = (which == 1) ? q1.size() : q3.size();
         if (sz == 0) break;
         @(negedge clk);
      end
      sz = (which == 1) ? q1.size() : q3.size();
      check("queue_drained", 32'(sz), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (ser_active1 || done1) begin
         if (q1.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut1_unexpected_output: got %b expected no activity (cyc=%0d)",
                     {ser_out1, ser_active1, busy1, done1, tx_ready1}, cyc);
         end else begin
            e1 = q1.pop_front();
            check("dut1_cycle", 32'(cyc), 32'(e1.cyc));
            check("dut1_outputs", {27'd0, ser_out1, ser_active1, busy1, done1, tx_ready1},
                  {27'd0, e1.v});
         end
      end
      if (ser_active3 || done3) begin
         if (q3.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut3_unexpected_output: got %b expected no activity (cyc=%0d)",
                     {ser_out3, ser_active3, busy3, done3, tx_ready3}, cyc);
         end else begin
            e3 = q3.pop_front();
            check("dut3_cycle", 32'(cyc), 32'(e3.cyc));
            check("dut3_outputs", {27'd0, ser_out3, ser_active3, busy3, done3, tx_ready3},
                  {27'd0, e3.v});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, a3, a4;
      rst_n     = 1'b0;
      tx_data1  = 8'h00;
      tx_data3  = 8'h00;
      tx_valid1 = 1'b0;
      tx_valid3 = 1'b0;
      #1;
      check("reset_outputs_dut1", {27'd0, ser_out1, ser_active1, busy1, done1, tx_ready1}, 0);
      check("reset_outputs_dut3", {27'd0, ser_out3, ser_active3, busy3, done3, tx_ready3}, 0);

      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      #1 check("ready_low_after_release", {31'd0, tx_ready1}, 32'd0);
      @(posedge clk);
      #1 check("ready_rises_first_edge", {30'd0, tx_ready1, tx_ready3}, 32'd3);
      @(negedge clk);

      // Idle with no valid: ready high, line quiet.
      for (int i = 0; i < 20; i++) begin
         check("idle_ready", {30'd0, tx_ready1, tx_ready3}, 32'd3);
         check("idle_ser_out", {30'd0, ser_out1, ser_out3}, 32'd0);
         check("idle_busy", {30'd0, busy1, busy3}, 32'd0);
         @(negedge clk);
      end

      // Single word 0xBD, valid dropped after acceptance.
      send(1, 8'hBD, a1);
      tx_valid1 = 1'b0;
      drain(1);

      // Back-to-back 0xBD, 0x53, then 0xFF presented during SHIFT of 0x53.
      send(1, 8'hBD, a1);
      send(1, 8'h53, a2);
      check("b2b_accept_in_done", 32'(a2), 32'(a1 + 9));
      send(1, 8'hFF, a3);
      check("ff_accept_at_done", 32'(a3), 32'(a2 + 9));
      tx_valid1 = 1'b0;
      drain(1);

      // Reset asserted during bit 4 of 0x53.
      send(1, 8'h53, a4);
      tx_valid1 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (cyc == a4 + 5) break;
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      q1.delete();
      #1 check("midreset_outputs", {27'd0, ser_out1, ser_active1, busy1, done1, tx_ready1}, 0);
      repeat (2) @(negedge clk);
      check("midreset_held", {29'd0, ser_out1, busy1, done1}, 32'd0);
      #2 rst_n = 1'b1;
      #1 check("midreset_ready_low", {31'd0, tx_ready1}, 32'd0);
      @(posedge clk);
      #1 check("midreset_ready_rises", {31'd0, tx_ready1}, 32'd1);
      @(negedge clk);
      send(1, 8'h81, a1);
      tx_valid1 = 1'b0;
      drain(1);

      // BIT_DIV=3: each bit held three cycles, done in cycle 25.
      send(3, 8'hA5, a1);
      tx_valid3 = 1'b0;
      drain(3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
